// File: rtl/wb_align_stage_pkg.sv
// rtl/wb_align_stage_pkg.sv - shared select codes, load sizes and FSM states for the write-back stage
package wb_align_stage_pkg;

  // write-data select codes
  localparam logic [3:0] ALU_C = 4'd0;
  localparam logic [3:0] DMEM  = 4'd1;
  localparam logic [3:0] U_EXT = 4'd2;
  localparam logic [3:0] PC4   = 4'd3;
  localparam logic [3:0] U_PC  = 4'd4;

  // load size codes
  localparam logic [1:0] LD_BYTE   = 2'd0;
  localparam logic [1:0] LD_HALF   = 2'd1;
  localparam logic [1:0] LD_WORD   = 2'd2;
  localparam logic [1:0] LD_DOUBLE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_load_extract.sv
// rtl/wb_load_extract.sv - picks nb bytes out of a two-word window and sign/zero-extends them
module wb_load_extract
  import wb_align_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OFFW = $clog2(XLEN / 8)
) (
  input  logic [2*XLEN-1:0] win,
  input  logic [OFFW-1:0]   off,
  input  logic [1:0]        ld_size,
  input  logic              ld_unsigned,
  output logic [XLEN-1:0]   ext
);

  logic [XLEN-1:0] shifted;
  logic [6:0]      nbits;
  logic [XLEN-1:0] hi_mask;
  logic [XLEN-1:0] sign_mask;
  logic            sign_bit;

  // shift the addressed byte down to bit 0, then fill everything above the access with the extension bit
  always_comb begin
    shifted   = XLEN'(win >> {off, 3'b000});
    nbits     = 7'd8 << ld_size;
    hi_mask   = {XLEN{1'b1}} << nbits;
    sign_mask = {{(XLEN-1){1'b0}}, 1'b1} << (nbits - 7'd1);
    sign_bit  = |(shifted & sign_mask);
    ext       = (shifted & ~hi_mask) | (hi_mask & {XLEN{sign_bit & ~ld_unsigned}});
  end

endmodule

// File: rtl/wb_align_stage.sv
// rtl/wb_align_stage.sv - registered write-back stage with load extraction and split-load merging
module wb_align_stage
  import wb_align_stage_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_wd_sel,
  input  logic [1:0]      in_ld_size,
  input  logic            in_ld_unsigned,
  input  logic [4:0]      in_rd,
  input  logic            in_we,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_u_ext_num,
  input  logic [XLEN-1:0] in_pc_addr,
  input  logic [XLEN-1:0] in_dmem_rd,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic [XLEN-1:0] out_wd,
  output logic            out_misalign
);

  localparam int BYTES = XLEN / 8;
  localparam int OFFW  = $clog2(BYTES);

  wb_state_e state_q, state_d;

  logic            is_load, crossing, size_bad, need_split, misalign_in;
  logic            load_direct, load_merged;
  logic [OFFW-1:0] in_off;
  logic [4:0]      end_byte;
  logic [XLEN-1:0] direct_wd, ext_val, mem_addr_d;

  logic [2*XLEN-1:0] ext_win;
  logic [OFFW-1:0]   ext_off;
  logic [1:0]        ext_size;
  logic              ext_uns;

  logic [4:0]      lat_rd;
  logic            lat_we;
  logic [OFFW-1:0] lat_off;
  logic [1:0]      lat_size;
  logic            lat_uns;
  logic [XLEN-1:0] lat_dmem;

  // classify the incoming instruction: load, word-crossing, unsupported size
  always_comb begin
    in_off      = in_alu_result[OFFW-1:0];
    end_byte    = 5'(in_off) + (5'd1 << in_ld_size);
    is_load     = (in_wd_sel == DMEM);
    crossing    = (end_byte > 5'(BYTES));
    size_bad    = (XLEN == 32) && (in_ld_size == LD_DOUBLE);
    need_split  = is_load && crossing && !size_bad && MISALIGN_EN;
    misalign_in = is_load && (size_bad || (crossing && !MISALIGN_EN));
    mem_addr_d  = (in_alu_result & ~XLEN'(BYTES - 1)) + XLEN'(BYTES);
  end

  // the extractor sees the latched split window in DATA, otherwise the current word with a zero upper half
  always_comb begin
    if (state_q == DATA) begin
      ext_win  = {mem_rdata, lat_dmem};
      ext_off  = lat_off;
      ext_size = lat_size;
      ext_uns  = lat_uns;
    end else begin
      ext_win  = {{XLEN{1'b0}}, in_dmem_rd};
      ext_off  = in_off;
      ext_size = in_ld_size;
      ext_uns  = in_ld_unsigned;
    end
  end

  wb_load_extract #(
    .XLEN (XLEN),
    .OFFW (OFFW)
  ) u_extract (
    .win         (ext_win),
    .off         (ext_off),
    .ld_size     (ext_size),
    .ld_unsigned (ext_uns),
    .ext         (ext_val)
  );

  // write-data mux for results that go straight to the output register
  always_comb begin
    case (in_wd_sel)
      ALU_C:   direct_wd = in_alu_result;
      DMEM:    direct_wd = misalign_in ? '0 : ext_val;
      U_EXT:   direct_wd = in_u_ext_num;
      PC4:     direct_wd = in_pc_addr + XLEN'(4);
      U_PC:    direct_wd = in_pc_addr + in_u_ext_num;
      default: direct_wd = '0;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state, handshake and output-register load strobes
  always_comb begin
    state_d     = state_q;
    in_ready    = 1'b0;
    mem_req     = 1'b0;
    load_direct = 1'b0;
    load_merged = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !out_valid || out_ready;
        if (in_valid && in_ready) begin
          if (need_split) state_d = REQ;
          else            load_direct = 1'b1;
        end
      end
      REQ: begin
        mem_req = 1'b1;
        state_d = DATA;
      end
      DATA: begin
        load_merged = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // capture a split load's fields and second-word address when it is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_rd   <= '0;
      lat_we   <= 1'b0;
      lat_off  <= '0;
      lat_size <= '0;
      lat_uns  <= 1'b0;
      lat_dmem <= '0;
      mem_addr <= '0;
    end else if (in_valid && in_ready && need_split) begin
      lat_rd   <= in_rd;
      lat_we   <= in_we;
      lat_off  <= in_off;
      lat_size <= in_ld_size;
      lat_uns  <= in_ld_unsigned;
      lat_dmem <= in_dmem_rd;
      mem_addr <= mem_addr_d;
    end
  end

  // output register: reload on a new result, drop valid when consumed, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_rd       <= '0;
      out_we       <= 1'b0;
      out_wd       <= '0;
      out_misalign <= 1'b0;
    end else if (load_direct) begin
      out_valid    <= 1'b1;
      out_rd       <= in_rd;
      out_we       <= in_we && !misalign_in;
      out_wd       <= direct_wd;
      out_misalign <= misalign_in;
    end else if (load_merged) begin
      out_valid    <= 1'b1;
      out_rd       <= lat_rd;
      out_we       <= lat_we;
      out_wd       <= ext_val;
      out_misalign <= 1'b0;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

endmodule

// File: doc/wb_align_stage.md
# wb_align_stage

Registered write-back stage for the pipelined core, generalising the single-cycle write-back mux. It selects the register-file write data (ALU result, load data, U-immediate, PC+4, PC+U-immediate), extracts and extends load data of any size at any byte offset, and handles loads that cross a word boundary. A crossing load either issues a second memory read and merges the two words, or is flagged as misaligned. Output is a valid/ready register toward the register-file write port.

## Interface
- XLEN, 32: data/address width, 32 or 64; BYTES = XLEN/8.
- MISALIGN_EN, 1: 1 = split and merge crossing loads; 0 = flag them as misaligned.

- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  MEM-stage result valid.
- in_ready  out  1  stage accepts input this cycle.
- in_wd_sel  in  4  write-data select code.
- in_ld_size  in  2  load size: 0 byte, 1 half, 2 word, 3 double.
- in_ld_unsigned  in  1  zero-extend instead of sign-extend.
- in_rd  in  5  destination register.
- in_we  in  1  register write enable.
- in_alu_result  in  XLEN  ALU result; the load byte address for loads.
- in_u_ext_num  in  XLEN  U-type immediate.
- in_pc_addr  in  XLEN  instruction PC.
- in_dmem_rd  in  XLEN  aligned memory word containing the load address.
- mem_req  out  1  second-word read request (split loads only).
- mem_addr  out  XLEN  second-word address.
- mem_rdata  in  XLEN  second-word data, valid the cycle after mem_req.
- out_valid  out  1  write-back result valid.
- out_ready  in  1  consumer accepts the result.
- out_rd  out  5  destination register.
- out_we  out  1  register write enable.
- out_wd  out  XLEN  write data.
- out_misalign  out  1  load exception; the write is suppressed.

## Operation
- Select codes:
  - ALU_C = 0: in_alu_result.
  - DMEM = 1: load path.
  - U_EXT = 2: in_u_ext_num.
  - PC4 = 3: in_pc_addr + 4.
  - U_PC = 4: in_pc_addr + in_u_ext_num.
  - Any other code: out_wd = 0, out_we unchanged.
- All additions wrap modulo 2^XLEN.
- Load path:
  - off = in_alu_result[log2(BYTES)-1:0]; nb = 1 << in_ld_size.
  - The access crosses a word boundary when off + nb > BYTES.
  - Non-crossing: take nb bytes starting at byte off (little-endian), then sign- or zero-extend to XLEN.
  - Crossing with MISALIGN_EN=1: form a 2*XLEN window as {mem_rdata, in_dmem_rd}, take nb bytes starting at off, then extend.
  - Crossing with MISALIGN_EN=0: out_misalign=1, out_we=0, out_wd=0.
  - in_ld_size=3 with XLEN=32 is always treated as misaligned.
- FSM states: IDLE, REQ, DATA.
  - IDLE: an accepted crossing load with MISALIGN_EN=1 latches the input fields, then goes to REQ. All other accepted inputs load the output register directly.
  - REQ: mem_req=1, mem_addr = (in_alu_result & ~(BYTES-1)) + BYTES, wrapping. Next state DATA.
  - DATA: merge with mem_rdata and load the output register. Next state IDLE.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - A transfer occurs on an edge where valid and ready are both 1.
  - The output register holds all out_* fields stable while out_valid=1 and out_ready=0.

## Timing
- Reset values:
  - out_valid, out_we, out_misalign, mem_req = 0.
  - out_wd, out_rd, mem_addr = 0.
  - State = IDLE.
  - in_ready = 1 once reset is released.
- Latency:
  - Non-split input accepted at edge E0: out_valid=1 after E0.
  - Split load: mem_req is high for exactly one cycle after E0. mem_rdata is sampled at E2. out_valid=1 after E2. in_ready=0 during REQ and DATA.
- Throughput: one result per cycle for non-split input while out_ready=1.
- Simultaneous consume and accept on the same edge: the output register is reloaded with the new result, with no bubble.
- Reset during REQ or DATA: the load is aborted, mem_req drops immediately, and no result is produced.

## Structure
- Shared constants in the common parameter header: select codes (ALU_C, DMEM, U_EXT, PC4, U_PC) and load-size codes.
- One sub-module, wb_load_extract: combinational. Inputs are the 2*XLEN window, off, ld_size and unsigned; output is the extended XLEN value. The non-split case drives the upper half of the window with zeros.

## Test plan
- XLEN=32, aligned word load: DMEM select, size 2, address 0x10000004, in_dmem_rd=0x8899AABB -> out_wd=0x8899AABB, out_we=1, one edge after accept. U_PC with PC 0x100 and immediate 0x2000 -> 0x2100. PC4 with PC 0x100 -> 0x104.
- Byte loads at offset 3 with in_dmem_rd=0x80112233: signed -> 0xFFFFFF80; unsigned -> 0x00000080. Half load at offset 1 -> 0x00001122 (signed).
- Split load, MISALIGN_EN=1: size 2 at address 0x1002, in_dmem_rd=0xDDCCBBAA, mem_rdata=0x44332211 -> mem_addr=0x1004, mem_req high one cycle, out_wd=0x2211DDCC two edges after accept, in_ready=0 for two cycles.
- Same load with MISALIGN_EN=0 -> out_misalign=1, out_we=0, out_wd=0, one edge after accept, mem_req never asserted.
- Backpressure: out_ready=0 with out_valid=1 and in_valid=1 -> in_ready=0 and outputs stable for 5 cycles. Raising out_ready -> the new input is accepted the same edge.
- rst_n pulsed low during DATA -> all outputs 0 asynchronously. After release, in_ready=1 and no stale result is emitted.
